// File: rtl/lt24_driver.sv
// rtl/lt24_driver.sv - LT24 (ILI9341) 8080-style write-bus driver: power-up sequence and RGB565 pixel streaming
module lt24_driver #(
    parameter int RESET_PULSE_CYCLES = 500,
    parameter int RESET_WAIT_CYCLES  = 6_000_000,
    parameter int WR_HALF_CYCLES     = 2,
    parameter int FRAME_PIXELS       = 76800
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pixel_rgb,
    input  logic        print,
    output logic        driver_done,
    output logic        driver_initialized,
    output logic        lcd_on,
    output logic        lcd_reset_n,
    output logic        lcd_cs_n,
    output logic        lcd_rs,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic [15:0] lcd_data
);

    localparam int MAXD_PW = (RESET_PULSE_CYCLES > WR_HALF_CYCLES) ? RESET_PULSE_CYCLES : WR_HALF_CYCLES;
    localparam int MAXD    = (MAXD_PW > RESET_WAIT_CYCLES) ? MAXD_PW : RESET_WAIT_CYCLES;
    localparam int CW      = $clog2(MAXD + 1);

    localparam logic [CW-1:0] C_PULSE = CW'(RESET_PULSE_CYCLES);
    localparam logic [CW-1:0] C_WAIT  = CW'(RESET_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] C_WR    = CW'(WR_HALF_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [16:0]   C_LAST_PIX = 17'(FRAME_PIXELS - 1);
    localparam logic [4:0]    C_LAST_IDX = 5'd16;

    typedef enum logic [2:0] {
        S_RST_LOW,
        S_RST_WAIT,
        S_SEQ,
        S_WR_LOW,
        S_WR_HIGH,
        S_DELAY,
        S_READY
    } state_t;

    typedef enum logic [1:0] {
        K_INIT,
        K_PIXEL,
        K_FRAME
    } kind_t;

    state_t        r_state, w_state_nxt;
    kind_t         r_kind, w_kind_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [4:0]    r_idx, w_idx_nxt;
    logic [15:0]   r_data, w_data_nxt;
    logic          r_rs, w_rs_nxt;
    logic          r_delay, w_delay_nxt;
    logic [16:0]   r_pix, w_pix_nxt;
    logic          r_done, w_done_nxt;
    logic          r_init, w_init_nxt;
    logic          r_cs_n, w_cs_n_nxt;
    logic          r_wr_n;
    logic          r_lcd_reset_n;
    logic          r_on;
    logic [9:0]    w_rom;

    // Init ROM entry packed as {rs, delay_flag, data[7:0]}
    function automatic logic [9:0] rom_entry(input logic [4:0] idx);
        case (idx)
            5'd0:    rom_entry = {1'b0, 1'b1, 8'h11};
            5'd1:    rom_entry = {1'b0, 1'b0, 8'h3A};
            5'd2:    rom_entry = {1'b1, 1'b0, 8'h55};
            5'd3:    rom_entry = {1'b0, 1'b0, 8'h36};
            5'd4:    rom_entry = {1'b1, 1'b0, 8'h28};
            5'd5:    rom_entry = {1'b0, 1'b0, 8'h29};
            5'd6:    rom_entry = {1'b0, 1'b0, 8'h2A};
            5'd7:    rom_entry = {1'b1, 1'b0, 8'h00};
            5'd8:    rom_entry = {1'b1, 1'b0, 8'h00};
            5'd9:    rom_entry = {1'b1, 1'b0, 8'h01};
            5'd10:   rom_entry = {1'b1, 1'b0, 8'h3F};
            5'd11:   rom_entry = {1'b0, 1'b0, 8'h2B};
            5'd12:   rom_entry = {1'b1, 1'b0, 8'h00};
            5'd13:   rom_entry = {1'b1, 1'b0, 8'h00};
            5'd14:   rom_entry = {1'b1, 1'b0, 8'h00};
            5'd15:   rom_entry = {1'b1, 1'b0, 8'hEF};
            default: rom_entry = {1'b0, 1'b0, 8'h2C};
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_kind_nxt  = r_kind;
        w_cnt_nxt   = (r_cnt != '0) ? (r_cnt - C_ONE) : r_cnt;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_rs_nxt    = r_rs;
        w_delay_nxt = r_delay;
        w_pix_nxt   = r_pix;
        w_done_nxt  = 1'b0;
        w_init_nxt  = r_init;
        w_cs_n_nxt  = r_cs_n;
        w_rom       = rom_entry(r_idx);

        case (r_state)
            S_RST_LOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RST_WAIT;
                    w_cnt_nxt   = C_WAIT;
                end
            end
            S_RST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_SEQ;
                    w_idx_nxt   = '0;
                    w_cs_n_nxt  = 1'b0;
                end
            end
            S_SEQ: begin
                w_rs_nxt    = w_rom[9];
                w_delay_nxt = w_rom[8];
                w_data_nxt  = {8'h00, w_rom[7:0]};
                w_kind_nxt  = K_INIT;
                w_state_nxt = S_WR_LOW;
                w_cnt_nxt   = C_WR;
            end
            S_WR_LOW: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_WR_HIGH;
                    w_cnt_nxt   = C_WR;
                end
            end
            S_WR_HIGH: begin
                if (r_cnt == '0) begin
                    case (r_kind)
                        K_INIT: begin
                            if (r_delay) begin
                                w_state_nxt = S_DELAY;
                                w_cnt_nxt   = C_WAIT;
                            end else if (r_idx == C_LAST_IDX) begin
                                w_state_nxt = S_READY;
                                w_init_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = S_SEQ;
                                w_idx_nxt   = r_idx + 5'd1;
                            end
                        end
                        K_PIXEL: begin
                            w_done_nxt = 1'b1;
                            // Frame boundary: re-issue memory write so the panel restarts at pixel 0
                            if (r_pix == C_LAST_PIX) begin
                                w_pix_nxt   = '0;
                                w_data_nxt  = 16'h002C;
                                w_rs_nxt    = 1'b0;
                                w_kind_nxt  = K_FRAME;
                                w_state_nxt = S_WR_LOW;
                                w_cnt_nxt   = C_WR;
                            end else begin
                                w_pix_nxt   = r_pix + 17'd1;
                                w_state_nxt = S_READY;
                            end
                        end
                        default: begin
                            w_state_nxt = S_READY;
                        end
                    endcase
                end
            end
            S_DELAY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_SEQ;
                    w_idx_nxt   = r_idx + 5'd1;
                end
            end
            S_READY: begin
                if (print) begin
                    w_data_nxt  = pixel_rgb;
                    w_rs_nxt    = 1'b1;
                    w_kind_nxt  = K_PIXEL;
                    w_state_nxt = S_WR_LOW;
                    w_cnt_nxt   = C_WR;
                end
            end
            default: begin
                w_state_nxt = S_RST_LOW;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_RST_LOW;
            r_kind        <= K_INIT;
            r_cnt         <= C_PULSE;
            r_idx         <= '0;
            r_data        <= '0;
            r_rs          <= 1'b1;
            r_delay       <= 1'b0;
            r_pix         <= '0;
            r_done        <= 1'b0;
            r_init        <= 1'b0;
            r_cs_n        <= 1'b1;
            r_wr_n        <= 1'b1;
            r_lcd_reset_n <= 1'b0;
            r_on          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_kind        <= w_kind_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_data        <= w_data_nxt;
            r_rs          <= w_rs_nxt;
            r_delay       <= w_delay_nxt;
            r_pix         <= w_pix_nxt;
            r_done        <= w_done_nxt;
            r_init        <= w_init_nxt;
            r_cs_n        <= w_cs_n_nxt;
            r_wr_n        <= (w_state_nxt != S_WR_LOW);
            r_lcd_reset_n <= (w_state_nxt != S_RST_LOW);
            r_on          <= 1'b1;
        end
    end

    assign driver_done        = r_done;
    assign driver_initialized = r_init;
    assign lcd_on             = r_on;
    assign lcd_reset_n        = r_lcd_reset_n;
    assign lcd_cs_n           = r_cs_n;
    assign lcd_rs             = r_rs;
    assign lcd_wr_n           = r_wr_n;
    assign lcd_rd_n           = 1'b1;
    assign lcd_data           = r_data;

endmodule

// File: tb/tb_lt24_driver.sv
// tb/tb_lt24_driver.sv - self-checking bench for lt24_driver
module tb_lt24_driver;

    localparam int P     = 4;
    localparam int WAIT  = 10;
    localparam int WR    = 2;
    localparam int FRAME = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] pixel_rgb = 16'h0000;
    logic        print = 1'b0;
    logic        driver_done, driver_initialized, lcd_on, lcd_reset_n;
    logic        lcd_cs_n, lcd_rs, lcd_wr_n, lcd_rd_n;
    logic [15:0] lcd_data;

    always #5 clk = ~clk;

    lt24_driver #(
        .RESET_PULSE_CYCLES(P),
        .RESET_WAIT_CYCLES (WAIT),
        .WR_HALF_CYCLES    (WR),
        .FRAME_PIXELS      (FRAME)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pixel_rgb         (pixel_rgb),
        .print             (print),
        .driver_done       (driver_done),
        .driver_initialized(driver_initialized),
        .lcd_on            (lcd_on),
        .lcd_reset_n       (lcd_reset_n),
        .lcd_cs_n          (lcd_cs_n),
        .lcd_rs            (lcd_rs),
        .lcd_wr_n          (lcd_wr_n),
        .lcd_rd_n          (lcd_rd_n),
        .lcd_data          (lcd_data)
    );

    typedef struct {
        logic        rs;
        logic [15:0] data;
        int          len;
        int          start;
        int          endc;
    } obs_t;

    typedef struct {
        logic        rs;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [15:0] pixel;
        logic        exp_rs;
        logic [15:0] exp_data;
        int          exp_lat;
    } pix_vec_t;

    int checks = 0;
    int failures = 0;

    // Bus monitor state
    int   cyc = 0;
    int   unstable = 0;
    int   cs_bad = 0;
    int   rd_bad = 0;
    int   hi_left = 0;
    int   init_rise = -1;
    int   done_cnt = 0;
    int   done_cyc = -1;
    bit   in_low = 0;
    logic prev_init = 1'b0;
    obs_t cur;
    obs_t obs_q[$];
    obs_t got_q[$];

    // Reference model
    exp_t exp_q[$];
    int   pix_count = 0;
    bit   frame_pending = 0;

    exp_t     init_rom[17];
    pix_vec_t pix_tab[4];

    always @(negedge clk) begin
        cyc++;
        if (lcd_rd_n !== 1'b1) rd_bad++;
        if (reset !== 1'b1) begin
            in_low  = 0;
            hi_left = 0;
        end else begin
            if (lcd_wr_n === 1'b0) begin
                if (!in_low) begin
                    in_low    = 1;
                    cur.rs    = lcd_rs;
                    cur.data  = lcd_data;
                    cur.start = cyc;
                    cur.len   = 0;
                    if (lcd_cs_n !== 1'b0) cs_bad++;
                end
                cur.len++;
                if (lcd_rs !== cur.rs || lcd_data !== cur.data) unstable++;
            end else if (in_low) begin
                in_low   = 0;
                cur.endc = cyc;
                obs_q.push_back(cur);
                hi_left  = WR - 1;
                if (lcd_rs !== cur.rs || lcd_data !== cur.data) unstable++;
            end else if (hi_left > 0) begin
                hi_left--;
                if (lcd_rs !== cur.rs || lcd_data !== cur.data) unstable++;
            end
            if (driver_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        if (driver_initialized === 1'b1 && prev_init !== 1'b1) init_rise = cyc;
        prev_init = driver_initialized;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic model_advance();
        pix_count++;
        if (pix_count == FRAME) begin
            exp_q.push_back('{1'b0, 16'h002C});
            pix_count     = 0;
            frame_pending = 1;
        end
    endtask

    task automatic model_pixel(input logic [15:0] v);
        exp_q.push_back('{1'b1, v});
        model_advance();
    endtask

    task automatic check_writes(input string name);
        exp_t e;
        obs_t o;
        int   w;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            w = 0;
            while (obs_q.size() == 0 && w < 400) begin
                tick();
                w++;
            end
            if (obs_q.size() == 0) begin
                fail_timeout({name, "_write"});
                exp_q.delete();
                return;
            end
            o = obs_q.pop_front();
            got_q.push_back(o);
            chk({name, "_rs"}, 32'(o.rs), 32'(e.rs));
            chk({name, "_data"}, 32'(o.data), 32'(e.data));
            chk({name, "_wr_low_len"}, o.len, WR);
        end
    endtask

    task automatic send_pixel(input logic [15:0] val, input bit drop, output int lat);
        int k;
        if (frame_pending) begin
            repeat (2 * WR) tick();
            frame_pending = 0;
        end
        tick();
        print     = 1'b1;
        pixel_rgb = val;
        tick();
        print = 1'b0;
        k = 1;
        if (drop) begin
            print     = 1'b1;
            pixel_rgb = ~val;
        end
        while (driver_done !== 1'b1 && k < 60) begin
            tick();
            k++;
            if (k == 2) print = 1'b0;
        end
        print = 1'b0;
        lat = k;
        if (k >= 60) fail_timeout("pixel_done");
        tick();
        chk("done_single_pulse", 32'(driver_done), 32'(0));
    endtask

    task automatic power_up();
        int n;
        reset = 1'b1;
        tick();
        chk("lcd_on_after_release", 32'(lcd_on), 32'(1));
        n = 0;
        while (lcd_reset_n === 1'b0 && n < 50) begin
            n++;
            tick();
        end
        chk("reset_pulse_len", n, P);
        got_q.delete();
        for (int i = 0; i < 17; i++) exp_q.push_back(init_rom[i]);
        check_writes("init");
        if (got_q.size() == 17) begin
            chk("gap_after_sleep_out", got_q[1].start - got_q[0].endc, WR + WAIT + 1);
            chk("gap_normal", got_q[2].start - got_q[1].endc, WR + 1);
        end
        n = 0;
        while (driver_initialized !== 1'b1 && n < 50) begin
            n++;
            tick();
        end
        if (n >= 50) fail_timeout("init_wait");
        else if (got_q.size() == 17) chk("init_rise_cycle", init_rise, got_q[16].endc + WR);
    endtask

    initial begin
        int         lat;
        int         n;
        int         d0;
        int         done_at;
        logic [15:0] v[3];
        logic [15:0] rv;

        init_rom[0]  = '{1'b0, 16'h0011};
        init_rom[1]  = '{1'b0, 16'h003A};
        init_rom[2]  = '{1'b1, 16'h0055};
        init_rom[3]  = '{1'b0, 16'h0036};
        init_rom[4]  = '{1'b1, 16'h0028};
        init_rom[5]  = '{1'b0, 16'h0029};
        init_rom[6]  = '{1'b0, 16'h002A};
        init_rom[7]  = '{1'b1, 16'h0000};
        init_rom[8]  = '{1'b1, 16'h0000};
        init_rom[9]  = '{1'b1, 16'h0001};
        init_rom[10] = '{1'b1, 16'h003F};
        init_rom[11] = '{1'b0, 16'h002B};
        init_rom[12] = '{1'b1, 16'h0000};
        init_rom[13] = '{1'b1, 16'h0000};
        init_rom[14] = '{1'b1, 16'h0000};
        init_rom[15] = '{1'b1, 16'h00EF};
        init_rom[16] = '{1'b0, 16'h002C};

        pix_tab[0] = '{16'hF81F, 1'b1, 16'hF81F, 2 * WR + 1};
        pix_tab[1] = '{16'h0000, 1'b1, 16'h0000, 2 * WR + 1};
        pix_tab[2] = '{16'hFFFF, 1'b1, 16'hFFFF, 2 * WR + 1};
        pix_tab[3] = '{16'h07E0, 1'b1, 16'h07E0, 2 * WR + 1};

        // Reset values
        repeat (3) tick();
        chk("rst_lcd_reset_n", 32'(lcd_reset_n), 32'(0));
        chk("rst_cs_n", 32'(lcd_cs_n), 32'(1));
        chk("rst_wr_n", 32'(lcd_wr_n), 32'(1));
        chk("rst_rd_n", 32'(lcd_rd_n), 32'(1));
        chk("rst_rs", 32'(lcd_rs), 32'(1));
        chk("rst_data", 32'(lcd_data), 32'(0));
        chk("rst_done", 32'(driver_done), 32'(0));
        chk("rst_init", 32'(driver_initialized), 32'(0));
        chk("rst_lcd_on", 32'(lcd_on), 32'(0));

        power_up();

        // Single pixels from the vector table
        for (int i = 0; i < 4; i++) begin
            send_pixel(pix_tab[i].pixel, 1'b0, lat);
            chk("pixel_done_latency", lat, pix_tab[i].exp_lat);
            exp_q.push_back('{pix_tab[i].exp_rs, pix_tab[i].exp_data});
            model_advance();
            check_writes("pixel_table");
        end

        // Print pulsed while busy is dropped
        send_pixel(16'h0F0F, 1'b1, lat);
        chk("busy_drop_latency", lat, 2 * WR + 1);
        model_pixel(16'h0F0F);
        check_writes("busy_drop");
        repeat (10) tick();
        chk("busy_drop_no_extra_write", obs_q.size(), 0);

        // Back-to-back with print held high
        v[0] = 16'h0000;
        v[1] = 16'hFFFF;
        v[2] = 16'h1234;
        d0 = done_cnt;
        got_q.delete();
        tick();
        print     = 1'b1;
        pixel_rgb = v[0];
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (lcd_wr_n !== 1'b0 && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) fail_timeout("b2b_accept");
            model_pixel(v[i]);
            if (i < 2) pixel_rgb = v[i+1];
            else print = 1'b0;
            n = 0;
            while (lcd_wr_n !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
        end
        check_writes("b2b");
        n = 0;
        while (done_cnt - d0 < 3 && n < 50) begin
            tick();
            n++;
        end
        repeat (8) tick();
        chk("b2b_done_count", done_cnt - d0, 3);
        if (got_q.size() == 3) begin
            chk("b2b_spacing_0", got_q[1].start - got_q[0].start, 2 * WR + 1);
            chk("b2b_spacing_1", got_q[2].start - got_q[1].start, 2 * WR + 1);
        end

        // Frame wrap
        while (pix_count != FRAME - 1) begin
            rv = 16'($urandom);
            send_pixel(rv, 1'b0, lat);
            model_pixel(rv);
            check_writes("pre_frame");
        end
        send_pixel(16'hABCD, 1'b0, lat);
        done_at = done_cyc;
        model_pixel(16'hABCD);
        got_q.delete();
        check_writes("frame");
        if (got_q.size() == 2) chk("frame_cmd_after_done", 32'(got_q[1].start >= done_at), 32'(1));
        repeat (10) tick();
        chk("frame_single_cmd", obs_q.size(), 0);
        send_pixel(16'h5A5A, 1'b0, lat);
        model_pixel(16'h5A5A);
        check_writes("after_frame");

        // Async reset mid-WR_LOW, then full restart
        chk("init_before_reset", 32'(driver_initialized), 32'(1));
        tick();
        print     = 1'b1;
        pixel_rgb = 16'h1357;
        tick();
        print = 1'b0;
        chk("in_wr_low_before_reset", 32'(lcd_wr_n), 32'(0));
        reset = 1'b0;
        #1;
        chk("async_wr_n", 32'(lcd_wr_n), 32'(1));
        chk("async_cs_n", 32'(lcd_cs_n), 32'(1));
        chk("async_lcd_reset_n", 32'(lcd_reset_n), 32'(0));
        chk("async_init", 32'(driver_initialized), 32'(0));
        chk("async_lcd_on", 32'(lcd_on), 32'(0));
        chk("async_data", 32'(lcd_data), 32'(0));
        repeat (3) tick();
        obs_q.delete();
        exp_q.delete();
        pix_count     = 0;
        frame_pending = 0;
        power_up();

        // Randomized stream against the model
        for (int i = 0; i < 30; i++) begin
            rv = 16'($urandom);
            send_pixel(rv, ($urandom_range(0, 3) == 0), lat);
            chk("rand_latency", lat, 2 * WR + 1);
            model_pixel(rv);
            check_writes("rand");
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (10) tick();
        chk("rand_no_extra_write", obs_q.size(), 0);

        chk("data_rs_stable", unstable, 0);
        chk("cs_low_during_writes", cs_bad, 0);
        chk("rd_n_always_high", rd_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lt24_driver.md
# lt24_driver

Drives the LT24 touch-panel LCD (ILI9341 controller) over its 16-bit 8080-style parallel write bus. The block runs the panel power-up sequence, then streams one RGB565 pixel per `print` request into a full-screen 320x240 window. It sits between the graphic controller (`pixel_rgb`/`print`/`driver_done`/`driver_initialized`) and the LT24 pins.

## Interface
- `RESET_PULSE_CYCLES`, default 500: `lcd_reset_n` low time (10 us at 50 MHz).
- `RESET_WAIT_CYCLES`, default 6_000_000: wait after hardware reset and after Sleep Out (120 ms at 50 MHz).
- `WR_HALF_CYCLES`, default 2: cycles `lcd_wr_n` stays low, and then high, per bus write (min 1).
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pixel_rgb` in 16: RGB565 pixel, sampled on the accepting `print` cycle.
- `print` in 1: pixel write request.
- `driver_done` out 1: one-cycle pulse when a pixel write finishes.
- `driver_initialized` out 1: high once init completes; stays high until reset.
- `lcd_on` out 1: backlight enable.
- `lcd_reset_n` out 1: panel hardware reset.
- `lcd_cs_n`, `lcd_rs`, `lcd_wr_n`, `lcd_rd_n` out 1 each: chip select, data(1)/command(0), write strobe, read strobe.
- `lcd_data` out 16: bus data.

## Operation
- Reset values: `lcd_reset_n`=0, `lcd_cs_n`=1, `lcd_wr_n`=1, `lcd_rd_n`=1, `lcd_rs`=1, `lcd_data`=0, `driver_done`=0, `driver_initialized`=0, `lcd_on`=0. `lcd_rd_n` stays 1 permanently; `lcd_on`=1 from the first cycle after reset release.
- States:
  - RST_LOW: `lcd_reset_n`=0 for RESET_PULSE_CYCLES, then RST_WAIT.
  - RST_WAIT: `lcd_reset_n`=1 for RESET_WAIT_CYCLES, then SEQ with index 0. `lcd_cs_n` goes low on leaving RST_WAIT and stays low until reset.
  - SEQ: loads entry {rs, data, delay} from the 17-entry init ROM, then WR_LOW.
  - WR_LOW: `lcd_wr_n`=0 for WR_HALF_CYCLES, then WR_HIGH.
  - WR_HIGH: `lcd_wr_n`=1 for WR_HALF_CYCLES. Exit: DELAY if the entry has its delay flag set; otherwise SEQ with index+1; otherwise READY after the last entry, after a pixel write, or after a frame command.
  - DELAY: RESET_WAIT_CYCLES, then SEQ with index+1.
  - READY: `driver_initialized`=1. On `print`=1: latch `pixel_rgb`, `lcd_rs`=1, go to WR_LOW.
- Init ROM, in order (C = command, rs=0; D = data, rs=1):
  - C 0x11 (delay flag set)
  - C 0x3A, D 0x55
  - C 0x36, D 0x28
  - C 0x29
  - C 0x2A, D 0x00, 0x00, 0x01, 0x3F
  - C 0x2B, D 0x00, 0x00, 0x00, 0xEF
  - C 0x2C
- 8-bit ROM values are zero-extended onto `lcd_data`.
- Pixel counter (17 bit) counts 0..76799 and increments on each completed pixel write.
  - When it wraps to 0 after pixel 76799, the block issues command 0x2C (rs=0, full WR_LOW/WR_HIGH cycle) before returning to READY. This keeps frames aligned with the upstream 76800-pixel scan.
  - No `driver_done` pulse is generated for the frame command.
- `print` is only accepted in READY. A `print` in any other state is dropped, not queued. The upstream must wait for `driver_done` before issuing the next request.
- `lcd_data` and `lcd_rs` are stable for the whole WR_LOW+WR_HIGH window.

## Timing
- Accepted `print` at cycle t:
  - `lcd_wr_n` low for cycles t+1 .. t+WR_HALF_CYCLES.
  - `lcd_wr_n` high for the next WR_HALF_CYCLES cycles.
  - `driver_done`=1 in cycle t+1+2*WR_HALF_CYCLES, which is the first READY cycle.
- A `print` in that same cycle is accepted, so back-to-back pixels take 2*WR_HALF_CYCLES+1 cycles each.
- `driver_initialized` rises in the first READY cycle after the final 0x2C init entry.
- Delay counter width is $clog2 of the largest delay parameter; counters load and count down to 0.
- Reset asserted mid-write or mid-init: all outputs take their reset values asynchronously, `driver_initialized` drops, and the full sequence restarts after release.

## Test plan
- Power-up with RESET_PULSE_CYCLES=4, RESET_WAIT_CYCLES=10, WR_HALF_CYCLES=2:
  - `lcd_reset_n` low exactly 4 cycles, then high.
  - The 17 bus writes occur in ROM order with correct rs and data values.
  - A 10-cycle gap follows 0x11.
  - `driver_initialized` rises after the last 0x2C.
- Single pixel: `print`=1 with `pixel_rgb`=0xF81F in READY:
  - `lcd_rs`=1 and `lcd_data`=0xF81F throughout.
  - `lcd_wr_n` low 2 cycles, then high 2 cycles.
  - `driver_done` pulses exactly once, 5 cycles after `print`.
- Back-to-back: `print` held high for 3 requests (0x0000, 0xFFFF, 0x1234):
  - 3 writes spaced 5 cycles apart.
  - 3 `driver_done` pulses.
- Busy drop: `print` pulsed during WR_LOW:
  - No extra write occurs.
  - The pixel counter is unchanged.
- Frame wrap: 76800 pixel writes:
  - After the last pixel's `driver_done`, exactly one rs=0 write of 0x2C occurs.
  - The next `print` then writes rs=1 data.
- Async reset (`reset`=0) mid-WR_LOW:
  - Same cycle: `lcd_wr_n`=1, `lcd_cs_n`=1, `lcd_reset_n`=0, `driver_initialized`=0.
  - After release, the init sequence repeats from RST_LOW.
